// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Opcodes, PSW layout, flag masks and sequencer states shared by
//            the execute-stage controller and the decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_ADDB   = 5'b00001;
   localparam logic [4:0] OP_ADDC   = 5'b00010;
   localparam logic [4:0] OP_ADDCB  = 5'b00011;
   localparam logic [4:0] OP_SUB    = 5'b00100;
   localparam logic [4:0] OP_SUBB   = 5'b00101;
   localparam logic [4:0] OP_SUBC   = 5'b00110;
   localparam logic [4:0] OP_SUBCB  = 5'b00111;
   localparam logic [4:0] OP_DADD   = 5'b01000;
   localparam logic [4:0] OP_DADDB  = 5'b01001;
   localparam logic [4:0] OP_CMP    = 5'b01010;
   localparam logic [4:0] OP_CMPB   = 5'b01011;
   localparam logic [4:0] OP_XOR    = 5'b01100;
   localparam logic [4:0] OP_XORB   = 5'b01101;
   localparam logic [4:0] OP_AND    = 5'b01110;
   localparam logic [4:0] OP_ANDB   = 5'b01111;
   localparam logic [4:0] OP_BIS    = 5'b10000;
   localparam logic [4:0] OP_BISB   = 5'b10001;
   localparam logic [4:0] OP_BIT    = 5'b10010;
   localparam logic [4:0] OP_BITB   = 5'b10011;
   localparam logic [4:0] OP_BIC    = 5'b10100;
   localparam logic [4:0] OP_BICB   = 5'b10101;
   localparam logic [4:0] OP_MOV    = 5'b10110;
   localparam logic [4:0] OP_MOVB   = 5'b10111;
   localparam logic [4:0] OP_SRA    = 5'b11000;
   localparam logic [4:0] OP_SRAB   = 5'b11001;
   localparam logic [4:0] OP_RRC    = 5'b11010;
   localparam logic [4:0] OP_RRCB   = 5'b11011;
   localparam logic [4:0] OP_ILL_MIN = 5'b11100;

   localparam int unsigned PSW_V = 4;
   localparam int unsigned PSW_S = 3;
   localparam int unsigned PSW_N = 2;
   localparam int unsigned PSW_Z = 1;
   localparam int unsigned PSW_C = 0;

   localparam logic [15:0] MASK_ARITH = 16'h0017;
   localparam logic [15:0] MASK_C     = 16'h0001;
   localparam logic [15:0] MASK_NZ    = 16'h0006;
   localparam logic [15:0] MASK_NONE  = 16'h0000;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_FIRE = 3'd2,
      S_WAIT = 3'd3,
      S_WB   = 3'd4
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_op_class.sv
// ============================================================================
// Module   : alu_op_class
// Purpose  : Classifies an ALU opcode into PSW update mask, write-back enable
//            and illegal flag; shared with the decoder's hazard logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_class
   import alu_pkg::*;
(
   input  logic [4:0]  op,
   output logic [15:0] psw_mask,
   output logic        wb_en,
   output logic        illegal
);

   always_comb begin
      psw_mask = MASK_NONE;
      wb_en    = 1'b0;
      illegal  = 1'b0;
      if (op >= OP_ILL_MIN) begin
         illegal = 1'b1;
      end else begin
         // compare and bit-test only produce flags
         wb_en = !(op inside {OP_CMP, OP_CMPB, OP_BIT, OP_BITB});
         if (op inside {[OP_ADD:OP_SUBCB], OP_CMP, OP_CMPB})
            psw_mask = MASK_ARITH;
         else if (op inside {OP_DADD, OP_DADDB, OP_RRC, OP_RRCB})
            psw_mask = MASK_C;
         else if (op inside {[OP_XOR:OP_MOVB]})
            psw_mask = MASK_NZ;
         else
            psw_mask = MASK_NONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
// ============================================================================
// Module   : alu_exec_ctrl
// Purpose  : Execute-stage sequencer: reads operands, fires the shared ALU,
//            waits its latency, writes back and merges flags into the PSW.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_op,
   input  logic [2:0]  in_src,
   input  logic [2:0]  in_dst,
   input  logic        in_imm_en,
   input  logic [15:0] in_imm,
   output logic [2:0]  rf_raddr_a,
   output logic [2:0]  rf_raddr_b,
   input  logic [15:0] rf_rdata_a,
   input  logic [15:0] rf_rdata_b,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic [15:0] alu_op1,
   output logic [15:0] alu_op2,
   output logic [4:0]  alu_instr,
   output logic        alu_e,
   input  logic [15:0] alu_result,
   input  logic [15:0] alu_psw,
   output logic [15:0] psw_q,
   output logic        done,
   output logic        err
);

   state_t      r_state, w_state_nxt;
   logic [4:0]  r_op;
   logic [2:0]  r_dst, r_src;
   logic        r_imm_en, r_illegal;
   logic [15:0] r_imm, r_op1, r_op2, r_psw, r_wdata;
   logic [4:0]  r_instr;
   logic [3:0]  r_cnt;

   logic [4:0]  w_cls_op;
   logic [15:0] w_mask;
   logic        w_wb_en, w_illegal, w_accept, w_wb_legal;

   // In IDLE the classifier looks at the incoming opcode to route illegal
   // ops straight to WB; afterwards it describes the captured opcode.
   assign w_cls_op = (r_state == S_IDLE) ? in_op : r_op;

   alu_op_class u_op_class (
      .op       (w_cls_op),
      .psw_mask (w_mask),
      .wb_en    (w_wb_en),
      .illegal  (w_illegal)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (in_valid) begin
               w_accept    = 1'b1;
               w_state_nxt = w_illegal ? S_WB : S_READ;
            end
         end
         S_READ:  w_state_nxt = S_FIRE;
         S_FIRE:  w_state_nxt = S_WAIT;
         S_WAIT:  if (r_cnt == 4'd1) w_state_nxt = S_WB;
         S_WB:    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_wb_legal = (r_state == S_WB) && !r_illegal && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_op      <= '0;
         r_dst     <= '0;
         r_src     <= '0;
         r_imm_en  <= 1'b0;
         r_imm     <= '0;
         r_illegal <= 1'b0;
         r_op1     <= '0;
         r_op2     <= '0;
         r_instr   <= '0;
         r_cnt     <= '0;
         r_psw     <= '0;
         r_wdata   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op      <= in_op;
            r_dst     <= in_dst;
            r_src     <= in_src;
            r_imm_en  <= in_imm_en;
            r_imm     <= in_imm;
            r_illegal <= w_illegal;
         end
         if (r_state == S_READ) begin
            r_op1   <= rf_rdata_a;
            r_op2   <= r_imm_en ? r_imm : rf_rdata_b;
            r_instr <= r_op;
         end
         if (r_state == S_FIRE)
            r_cnt <= 4'(ALU_LAT);
         else if (r_state == S_WAIT)
            r_cnt <= r_cnt - 4'd1;
         if (w_wb_legal) begin
            r_psw   <= (r_psw & ~w_mask) | (alu_psw & w_mask);
            r_wdata <= alu_result;
         end
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign alu_e      = (r_state == S_FIRE) && !rst;
   assign done       = (r_state == S_WB) && !rst;
   assign err        = done && r_illegal;
   assign rf_we      = w_wb_legal && w_wb_en;
   assign rf_waddr   = r_dst;
   assign rf_raddr_a = r_dst;
   assign rf_raddr_b = r_src;
   assign rf_wdata   = w_wb_legal ? alu_result : r_wdata;
   assign alu_op1    = r_op1;
   assign alu_op2    = r_op2;
   assign alu_instr  = r_instr;
   assign psw_q      = r_psw;

endmodule

`default_nettype wire

// File: doc/alu_exec_ctrl.md
# alu_exec_ctrl

Execute-stage sequencer for the shared 16-bit ALU. Accepts one decoded two-operand instruction at a time over a valid/ready handshake, reads operands from the register file, strobes the ALU enable, waits a fixed latency, then writes the result back and merges the returned flags into the architectural PSW it owns. It sits between the decoder and the ALU/register-file pair and is the only block that drives the ALU's operand, opcode and enable inputs.

## Interface
- ALU_LAT, 2, cycles from the end of the alu_e pulse until alu_result/alu_psw are valid; legal range 1–15.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  high only in IDLE.
- in_op  in  5  ALU opcode; bit 0 selects byte (.b) form.
- in_src, in_dst  in  3  register indices; dst is also operand 1.
- in_imm_en  in  1  operand 2 comes from in_imm instead of rf[in_src].
- in_imm  in  16  immediate/constant value.
- rf_raddr_a, rf_raddr_b  out  3  read addresses (a = dst, b = src).
- rf_rdata_a, rf_rdata_b  in  16  combinational read data.
- rf_we  out  1  write strobe, one cycle.
- rf_waddr  out  3  write address (= captured dst).
- rf_wdata  out  16  write data (= captured alu_result).
- alu_op1, alu_op2  out  16  held operands (op1 = dst value, op2 = src/imm).
- alu_instr  out  5  held opcode.
- alu_e  out  1  one-cycle enable pulse.
- alu_result  in  16  ALU result.
- alu_psw  in  16  ALU flag output; bits V=4, S=3, N=2, Z=1, C=0.
- psw_q  out  16  architectural PSW; also drives the ALU's PSW input.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle, coincident with done, for illegal opcode.

## Operation
- States: IDLE, READ, FIRE, WAIT, WB.
- IDLE: in_ready=1. On in_valid, latch op/src/dst/imm_en/imm. If op ≥ 5'b11100, go to WB with the illegal flag set. Otherwise go to READ.
- READ: drive rf_raddr_a=dst and rf_raddr_b=src. Capture alu_op1=rf_rdata_a. Capture alu_op2=imm_en ? imm : rf_rdata_b. Go to FIRE.
- FIRE: alu_e=1 for exactly one cycle. Load wait counter with ALU_LAT. Go to WAIT.
- WAIT: decrement the counter. When it reaches 1, go to WB.
- WB: done=1.
  - Legal op: sample alu_result and alu_psw in this cycle. Assert rf_we unless op ∈ {cmp 01010, cmp.b 01011, bit 10010, bit.b 10011}. Apply the PSW merge. Return to IDLE.
  - Illegal op: err=1, rf_we=0, PSW unchanged. Return to IDLE.
- PSW merge: psw_q ← (psw_q & ~mask) | (alu_psw & mask). Mask by op class:
  - arithmetic 00000–00111, 01010, 01011: V, N, Z, C (0x0017).
  - dadd 01000, 01001: C (0x0001).
  - logic/bit 01100–10111: N, Z (0x0006).
  - sra 11000, 11001: none (0x0000).
  - rrc 11010, 11011: C (0x0001).
- PSW bit S and bits 15:5 are never modified by this block.
- in_src == in_dst is legal; both read ports see the same register.
- Operand and opcode outputs hold their values from READ until the next accept.

## Timing
- Accept at edge T. READ during T+1, FIRE during T+2, WAIT during T+3 … T+2+ALU_LAT, WB during T+3+ALU_LAT.
- Accept-to-done latency: 3+ALU_LAT cycles (5 at the default). Illegal op: done/err one cycle after accept.
- Next accept is possible the cycle after WB; sustained throughput is one instruction per 4+ALU_LAT cycles.
- in_valid while in_ready=0 is ignored; the source must hold it until accepted.
- Reset values: state=IDLE, in_ready=1 (the cycle after rst deasserts), psw_q=0, alu_op1=alu_op2=0, alu_instr=0, rf_raddr_*=0, rf_waddr=0, rf_wdata=0. alu_e, rf_we, done and err are all 0.
- rst in any state: next edge goes to IDLE. Any pending write or PSW update is dropped and alu_e is forced low. rst has priority over in_valid.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_ADD … OP_RRCB).
  - PSW bit indices (PSW_V/S/N/Z/C).
  - state enum.
  - PSW class masks.
- Sub-module alu_op_class: combinational, in_op → {psw_mask[15:0], wb_en, illegal}. It is reused by the decoder for hazard checks.
- The FSM, wait counter and PSW register live in alu_exec_ctrl.

## Test plan
- Reset, then add: r1=0x7FFF, r2=0x0001, op 00000, src=2, dst=1. Expect done at accept+5, rf_we with waddr=1 and wdata=0x8000, V=1, N=1, Z=0, C=0.
- cmp: r3=r4=0x1234, op 01010. Expect done with rf_we=0, Z=1, N=0, V=0, C=0; r3 unchanged.
- xor.b immediate: in_imm_en=1, imm=0x00FF, r5=0xAB0F, op 01101. Expect wdata=0xABF0, N=1, Z=0; C and V keep their prior values.
- Illegal op 11110 with psw_q=0x0013. Expect done=err=1 one cycle after accept, rf_we=0, psw_q remains 0x0013, in_ready=1 the next cycle.
- Back-to-back with in_valid held high: expect the second accept exactly one cycle after the first done; in_valid is ignored during READ/FIRE/WAIT/WB.
- rst asserted during WAIT: expect no rf_we and no done, psw_q=0, and IDLE/in_ready=1 the cycle after rst drops.
